// File: rtl/seg7_arbiter.sv
// Round-robin time-sharing of the four-digit seven-segment display among three
// requesters, with a minimum on-screen hold and blanking when nobody requests.
module seg7_arbiter #(
    parameter logic [23:0] HOLD_CYCLES = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [3:0]  mask0,
    input  logic [3:0]  mask1,
    input  logic [3:0]  mask2,
    output logic [2:0]  grant,
    output logic [15:0] num,
    output logic [3:0]  sel,
    output logic        switch_pulse
);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_owner, w_owner_next;
    logic [1:0]  r_last,  w_last_next;
    logic [23:0] r_cnt,   w_cnt_next;
    logic [2:0]  r_grant, w_grant_next;
    logic        r_pulse, w_pulse_next;
    logic [15:0] r_num;
    logic [3:0]  r_sel;
    logic [2:0]  w_pick;
    logic [2:0]  w_others;

    function automatic logic [1:0] succ(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] k);
        return 3'b001 << k;
    endfunction

    // Returns {valid, index} of the first set bit of r scanning base, base+1, base+2 (mod 3).
    function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [2:0] r);
        logic [2:0] res;
        int         t;
        res = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            t = int'(base) + i;
            if (t >= 3) t = t - 3;
            if (r[t[1:0]]) res = {1'b1, t[1:0]};
        end
        return res;
    endfunction

    assign w_others = req & ~onehot(r_owner);

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_last_next  = r_last;
        w_cnt_next   = (r_cnt == 24'd0) ? 24'd0 : r_cnt - 24'd1;
        w_pick       = 3'b000;
        case (r_state)
            IDLE: begin
                w_pick     = rr_pick(succ(r_last), req);
                w_cnt_next = 24'd0;
                if (w_pick[2]) begin
                    w_state_next = SHOW;
                    w_owner_next = w_pick[1:0];
                    w_last_next  = w_pick[1:0];
                    w_cnt_next   = HOLD_CYCLES - 24'd1;
                end
            end
            default: begin
                w_pick = rr_pick(succ(r_owner), w_others);
                // Owner release preempts the hold; otherwise rotate only once the hold expires.
                if (!req[r_owner] || (r_cnt == 24'd0)) begin
                    if (w_pick[2]) begin
                        w_owner_next = w_pick[1:0];
                        w_last_next  = w_pick[1:0];
                        w_cnt_next   = HOLD_CYCLES - 24'd1;
                    end else if (!req[r_owner]) begin
                        w_state_next = IDLE;
                        w_cnt_next   = 24'd0;
                    end
                end
            end
        endcase
        w_grant_next = (w_state_next == SHOW) ? onehot(w_owner_next) : 3'b000;
        w_pulse_next = (w_grant_next != r_grant);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_last  <= 2'd2;
            r_cnt   <= 24'd0;
            r_grant <= 3'b000;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
            r_grant <= w_grant_next;
            r_pulse <= w_pulse_next;
        end
    end

    // Display follows the current owner live, one cycle behind the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num <= 16'h0000;
            r_sel <= 4'b0000;
        end else if (r_state == SHOW) begin
            case (r_owner)
                2'd0:    begin r_num <= data0; r_sel <= mask0; end
                2'd1:    begin r_num <= data1; r_sel <= mask1; end
                default: begin r_num <= data2; r_sel <= mask2; end
            endcase
        end else begin
            r_num <= 16'h0000;
            r_sel <= 4'b0000;
        end
    end

    assign grant        = r_grant;
    assign num          = r_num;
    assign sel          = r_sel;
    assign switch_pulse = r_pulse;

endmodule
